dot_product_engine: RTL and testbench
=====================================

# dot_product_engine

Self-contained dot-product engine: a controller collects two 8-element unsigned 8-bit vectors A and B from a byte-serial input, stores them in a 16x8 RAM, runs a sequential multiply-accumulate datapath and presents the 8-bit result on a display port. It sits between a byte-entry front end (keypad/switch debouncer) and a display driver. Internally it comprises a controller FSM, a MEM16x8-style RAM with an address/write mux, and a dot-product sequencer.

## Interface
- No parameters; vector length 8, data width 8, RAM depth 16 are fixed.
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- input_value  input  8  unsigned element value; also the RAM write data.
- input_value_ready  input  1  element-valid strobe; accepted on its rising edge.
- input_enable  output  1  high while in S_INPUT_A or S_INPUT_B.
- mode_compute  output  1  high in S_COMPUTE; datapath owns the RAM address bus.
- comp_start  output  1  one-cycle start pulse to the datapath.
- comp_done  output  1  one-cycle done pulse from the datapath.
- display_enable  output  1  high in S_DISPLAY.
- display_value  output  8  final result; 0 outside S_DISPLAY.
- state  output  2  controller state code (observability).

## Operation
- Controller states: S_INPUT_A=0, S_INPUT_B=1, S_COMPUTE=2, S_DISPLAY=3.
- Element acceptance: registered copy of input_value_ready; accept when ready=1 and previous sample=0, and input_enable=1. Holding ready high writes once; edges in S_COMPUTE/S_DISPLAY are ignored.
- S_INPUT_A: each accepted element is written to RAM[idx], idx 0..7. After the 8th write, idx clears and the state becomes S_INPUT_B.
- S_INPUT_B: writes go to RAM[8+idx]. After the 8th write, the state becomes S_COMPUTE and comp_start pulses for the first cycle in S_COMPUTE.
- RAM: 16x8, synchronous write when WR=1, combinational read. Address/WR mux: mode_compute=1 selects the datapath address with WR forced 0; otherwise the controller address and write strobe are used. RAM contents are not cleared by reset.
- Datapath FSM: IDLE, RD_A, RD_B, DONE.
  - IDLE: on start, clear k and acc.
  - RD_A: address k, latch a_reg.
  - RD_B: address 8+k, acc += a_reg*DATA_OUT. Go to DONE when k=7, else k+1 and back to RD_A.
  - DONE: comp_done=1 for one cycle and result registered, then IDLE. A start arriving outside IDLE is ignored.
- Arithmetic: unsigned 8x8 gives a 16-bit product; acc is 19 bits (maximum 520200 fits). result = acc[7:0] (modulo 256), unless changed by Configuration.
- S_COMPUTE: leave for S_DISPLAY on the edge where comp_done=1, latching result into display_value.
- S_DISPLAY: display_enable=1 and display_value held. This state is terminal until reset.

## Timing
- Reset values: state=S_INPUT_A, input_enable=1, all other outputs 0; datapath IDLE, acc=0, result=0.
- Write latency: a ready rising edge sampled at edge N writes RAM at edge N. The 16th element's edge is also the edge that enters S_COMPUTE.
- comp_start is high in cycle C (the first S_COMPUTE cycle). comp_done is high in cycle C+17. display_enable rises in cycle C+18.
- Reset asserted mid-operation: all FSMs and registers return to reset values immediately (asynchronously). Entry restarts at A[0]. RAM keeps stale data, which is overwritten on re-entry.
- Back-to-back ready edges, including one per 2 cycles, must all be accepted.

## Configuration
- DOT_SATURATE_EN defined: result = 255 when acc > 255, else acc[7:0].
- DOT_SATURATE_EN undefined: result = acc[7:0] (wraps).

## Test plan
- A=1..8, B=2..9, one-cycle ready pulses 3 cycles apart -> comp_done 17 cycles after comp_start; display_enable=1, display_value=240, state=3.
- A=all 0, B=any -> display_value=0.
- A=B=all 16 -> acc=2048. Without macro display_value=0; with DOT_SATURATE_EN display_value=255.
- ready held high 5 cycles per element -> exactly one write per element; state sequence 0->1 after 8 elements, 1->2 after 16.
- Reset pulse during S_COMPUTE -> outputs return to reset values; re-entering A=1..8, B=1..8 gives display_value=204.
- Ready edges in S_DISPLAY -> display_value and state unchanged.

Source files
------------

// File: rtl/dot_product_engine.sv
// dot_product_engine: collects two 8-byte vectors into a 16x8 RAM and runs
// a sequential multiply-accumulate. Optional macro: DOT_SATURATE_EN clamps the result.
module dot_product_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_value,
  input  logic       input_value_ready,
  output logic       input_enable,
  output logic       mode_compute,
  output logic       comp_start,
  output logic       comp_done,
  output logic       display_enable,
  output logic [7:0] display_value,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_INPUT_A = 2'd0,
    S_INPUT_B = 2'd1,
    S_COMPUTE = 2'd2,
    S_DISPLAY = 2'd3
  } ctrl_t;

  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_RD_A = 2'd1,
    DP_RD_B = 2'd2,
    DP_DONE = 2'd3
  } dp_t;

  ctrl_t       cs, cn;
  logic [2:0]  idx, idx_n;
  logic        ready_q;
  logic        accept;
  logic        start_q, start_n;

  dp_t         ds, dn;
  logic [2:0]  k, k_n;
  logic [7:0]  a_reg, a_n;
  logic [18:0] acc, acc_n;
  logic [7:0]  result_q, result_n;
  logic [15:0] prod;

  logic [7:0]  mem [16];
  logic [3:0]  ram_addr;
  logic [3:0]  dp_addr;
  logic        ram_we;
  logic [7:0]  data_out;

  assign state          = cs;
  assign input_enable   = (cs == S_INPUT_A) || (cs == S_INPUT_B);
  assign mode_compute   = (cs == S_COMPUTE);
  assign display_enable = (cs == S_DISPLAY);
  assign comp_start     = start_q;
  assign comp_done      = (ds == DP_DONE);
  assign display_value  = display_enable ? result_q : 8'd0;

  assign accept = input_value_ready && !ready_q && input_enable;

  assign dp_addr  = (ds == DP_RD_B) ? {1'b1, k} : {1'b0, k};
  assign ram_addr = mode_compute ? dp_addr
                                 : {cs == S_INPUT_B, idx};
  assign ram_we   = mode_compute ? 1'b0 : accept;
  assign data_out = mem[ram_addr];
  assign prod     = a_reg * data_out;

  // Final result from the accumulator, wrapped or clamped.
  always_comb begin
`ifdef DOT_SATURATE_EN
    result_n = (acc > 19'd255) ? 8'hFF : acc[7:0];
`else
    result_n = acc[7:0];
`endif
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= input_value;
  end

  // Controller registers and ready edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs      <= S_INPUT_A;
      idx     <= 3'd0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      cs      <= cn;
      idx     <= idx_n;
      ready_q <= input_value_ready;
      start_q <= start_n;
    end
  end

  // Controller next-state: entry of A, then B, then compute, then hold.
  always_comb begin
    cn      = cs;
    idx_n   = idx;
    start_n = 1'b0;
    unique case (cs)
      S_INPUT_A: begin
        if (accept) begin
          if (idx == 3'd7) begin
            idx_n = 3'd0;
            cn    = S_INPUT_B;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      S_INPUT_B: begin
        if (accept) begin
          if (idx == 3'd7) begin
            idx_n   = 3'd0;
            cn      = S_COMPUTE;
            start_n = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      S_COMPUTE: begin
        if (comp_done)
          cn = S_DISPLAY;
      end
      S_DISPLAY: begin
        cn = S_DISPLAY;
      end
      default: cn = S_INPUT_A;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ds       <= DP_IDLE;
      k        <= 3'd0;
      a_reg    <= 8'd0;
      acc      <= 19'd0;
      result_q <= 8'd0;
    end else begin
      ds    <= dn;
      k     <= k_n;
      a_reg <= a_n;
      acc   <= acc_n;
      if (ds == DP_DONE)
        result_q <= result_n;
    end
  end

  // Datapath sequencer: read A[k], then B[k] and accumulate.
  always_comb begin
    dn    = ds;
    k_n   = k;
    a_n   = a_reg;
    acc_n = acc;
    unique case (ds)
      DP_IDLE: begin
        if (comp_start) begin
          k_n   = 3'd0;
          acc_n = 19'd0;
          dn    = DP_RD_A;
        end
      end
      DP_RD_A: begin
        a_n = data_out;
        dn  = DP_RD_B;
      end
      DP_RD_B: begin
        acc_n = acc + {3'd0, prod};
        if (k == 3'd7) begin
          dn = DP_DONE;
        end else begin
          k_n = k + 3'd1;
          dn  = DP_RD_A;
        end
      end
      DP_DONE: begin
        dn = DP_IDLE;
      end
      default: dn = DP_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: scoreboard bench for dot_product_engine.
// Expected results are queued when vectors are driven, popped at display.
module tb_dot_product_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] input_value;
  logic       input_value_ready;
  logic       input_enable;
  logic       mode_compute;
  logic       comp_start;
  logic       comp_done;
  logic       display_enable;
  logic [7:0] display_value;
  logic [1:0] state;

  dot_product_engine dut (
    .clk               (clk),
    .rst               (rst),
    .input_value       (input_value),
    .input_value_ready (input_value_ready),
    .input_enable      (input_enable),
    .mode_compute      (mode_compute),
    .comp_start        (comp_start),
    .comp_done         (comp_done),
    .display_enable    (display_enable),
    .display_value     (display_value),
    .state             (state)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;
  int exp_q[$];

  int   cyc = 0;
  int   start_cyc = -1;
  int   done_cyc = -1;
  int   disp_cyc = -1;
  logic disp_prev = 1'b0;

  // Cycle markers for start/done/display timing.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (comp_start) start_cyc = cyc;
    if (comp_done) done_cyc = cyc;
    if (display_enable && !disp_prev) disp_cyc = cyc;
    disp_prev = display_enable;
  end

  typedef logic [7:0] vec_t [8];

  function automatic int model(input vec_t a, input vec_t b);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += int'(a[i]) * int'(b[i]);
`ifdef DOT_SATURATE_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    input_value = 8'd0;
    input_value_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_cyc = -1;
    done_cyc = -1;
    disp_cyc = -1;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v, input int hold, input int gap);
    input_value = v;
    input_value_ready = 1'b1;
    repeat (hold) @(negedge clk);
    input_value_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic load(input vec_t a, input vec_t b, input int hold,
                      input int gap);
    for (int i = 0; i < 8; i++) send(a[i], hold, gap);
    for (int i = 0; i < 8; i++) send(b[i], hold, gap);
  endtask

  task automatic await_display(input string name);
    int n;
    int e;
    n = 0;
    while (!display_enable && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    tests_run++;
    if (!display_enable) begin
      fails++;
      $display("FAIL %s timeout: display_enable=%0b required 1", name,
               display_enable);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (display_value !== 8'(e)) begin
      fails++;
      $display("FAIL %s value: got %0d required %0d", name,
               display_value, e);
    end
    tests_run++;
    if (state !== 2'd3) begin
      fails++;
      $display("FAIL %s state: got %0d required 3", name, state);
    end
    tests_run++;
    if (done_cyc - start_cyc !== 17) begin
      fails++;
      $display("FAIL %s done latency: got %0d required 17", name,
               done_cyc - start_cyc);
    end
    tests_run++;
    if (disp_cyc - done_cyc !== 1) begin
      fails++;
      $display("FAIL %s display latency: got %0d required 1", name,
               disp_cyc - done_cyc);
    end
  endtask

  task automatic run(input string name, input vec_t a, input vec_t b,
                     input int hold, input int gap);
    exp_q.push_back(model(a, b));
    load(a, b, hold, gap);
    await_display(name);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({state, input_enable, mode_compute, comp_start, comp_done,
         display_enable} !== 7'b00_1_0_0_0_0) begin
      fails++;
      $display("FAIL reset ctrl: got st=%0d ie=%0b mc=%0b cs=%0b cd=%0b de=%0b required 0 1 0 0 0 0",
               state, input_enable, mode_compute, comp_start, comp_done,
               display_enable);
    end
    tests_run++;
    if (display_value !== 8'd0) begin
      fails++;
      $display("FAIL reset display_value: got %0d required 0",
               display_value);
    end
  endtask

  task automatic test_basic();
    vec_t a, b;
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'(i + 1);
      b[i] = 8'(i + 2);
    end
    do_reset();
    exp_q.push_back(240);
    load(a, b, 1, 2);
    await_display("basic");
  endtask

  task automatic test_zero();
    vec_t a, b;
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'd0;
      b[i] = 8'($urandom_range(0, 255));
    end
    do_reset();
    run("zero", a, b, 1, 1);
  endtask

  task automatic test_saturate();
    vec_t a, b;
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'd16;
      b[i] = 8'd16;
    end
    do_reset();
`ifdef DOT_SATURATE_EN
    exp_q.push_back(255);
`else
    exp_q.push_back(0);
`endif
    load(a, b, 1, 1);
    await_display("sat16");
  endtask

  task automatic test_held();
    vec_t a, b;
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'(i + 1);
      b[i] = 8'(i + 2);
    end
    do_reset();
    exp_q.push_back(240);
    for (int i = 0; i < 7; i++) send(a[i], 5, 1);
    tests_run++;
    if (state !== 2'd0) begin
      fails++;
      $display("FAIL held after7: state %0d required 0", state);
    end
    send(a[7], 5, 1);
    tests_run++;
    if (state !== 2'd1) begin
      fails++;
      $display("FAIL held after8: state %0d required 1", state);
    end
    for (int i = 0; i < 8; i++) send(b[i], 5, 1);
    tests_run++;
    if (state !== 2'd2 || mode_compute !== 1'b1) begin
      fails++;
      $display("FAIL held after16: state %0d mc %0b required 2 1",
               state, mode_compute);
    end
    await_display("held");
  endtask

  task automatic test_reset_mid();
    vec_t a, b;
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'(i + 1);
      b[i] = 8'(i + 2);
    end
    do_reset();
    load(a, b, 1, 1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (state !== 2'd2) begin
      fails++;
      $display("FAIL midrst pre: state %0d required 2", state);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({state, input_enable, mode_compute, comp_start, comp_done,
         display_enable, display_value} !== 15'b00_1_0_0_0_0_00000000) begin
      fails++;
      $display("FAIL midrst async: got st=%0d ie=%0b mc=%0b de=%0b dv=%0d required 0 1 0 0 0",
               state, input_enable, mode_compute, display_enable,
               display_value);
    end
    @(negedge clk);
    rst = 1'b1;
    start_cyc = -1;
    done_cyc = -1;
    disp_cyc = -1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) b[i] = 8'(i + 1);
    exp_q.push_back(204);
    load(a, b, 1, 2);
    await_display("midrst");
  endtask

  task automatic test_display_edges();
    for (int i = 0; i < 3; i++) send(8'(50 + i), 1, 1);
    tests_run++;
    if (display_value !== 8'd204 || state !== 2'd3) begin
      fails++;
      $display("FAIL disp_edges: dv %0d st %0d required 204 3",
               display_value, state);
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        a[i] = 8'($urandom_range(0, 255));
        b[i] = 8'($urandom_range(0, 255));
      end
      if (r == 0) for (int i = 0; i < 8; i++) begin
        a[i] = 8'd255;
        b[i] = 8'd255;
      end
      do_reset();
      run("b2b", a, b, 1, 1);
    end
  endtask

  initial begin
    rst = 1'b0;
    input_value = 8'd0;
    input_value_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_saturate();
    test_held();
    test_reset_mid();
    test_display_edges();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
